// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared state type and index helper for the burst mem_cmd arbiter
package bp_me_pkg;

   typedef enum logic [0:0] {
      e_idle,
      e_data
   } bp_me_burst_arb_state_e;

   function automatic int next_idx(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/bp_me_burst_mem_cmd_arb_if.sv
// rtl/bp_me_burst_mem_cmd_arb_if.sv - requester-side and CCE-MEM-side mem_cmd bus bundle
interface bp_me_burst_mem_cmd_arb_if #(
   parameter int num_req_p      = 2,
   parameter int header_width_p = 128,
   parameter int data_width_p   = 64,
   parameter int max_beats_p    = 8
) ();
   localparam int lg_beats_lp = $clog2(max_beats_p + 1);

   logic [num_req_p*header_width_p-1:0] req_header_i;
   logic [num_req_p*lg_beats_lp-1:0]    req_header_beats_i;
   logic [num_req_p-1:0]                req_header_v_i;
   logic [num_req_p-1:0]                req_header_ready_o;
   logic [num_req_p*data_width_p-1:0]   req_data_i;
   logic [num_req_p-1:0]                req_data_v_i;
   logic [num_req_p-1:0]                req_data_ready_o;

   logic [header_width_p-1:0]           mem_cmd_header_o;
   logic                                mem_cmd_header_v_o;
   logic                                mem_cmd_header_ready_i;
   logic [data_width_p-1:0]             mem_cmd_data_o;
   logic                                mem_cmd_data_v_o;
   logic                                mem_cmd_data_ready_i;

   modport slave (
      input  req_header_i, req_header_beats_i, req_header_v_i,
      output req_header_ready_o,
      input  req_data_i, req_data_v_i,
      output req_data_ready_o,
      output mem_cmd_header_o, mem_cmd_header_v_o,
      input  mem_cmd_header_ready_i,
      output mem_cmd_data_o, mem_cmd_data_v_o,
      input  mem_cmd_data_ready_i
   );

   modport master (
      output req_header_i, req_header_beats_i, req_header_v_i,
      input  req_header_ready_o,
      output req_data_i, req_data_v_i,
      input  req_data_ready_o,
      input  mem_cmd_header_o, mem_cmd_header_v_o,
      output mem_cmd_header_ready_i,
      input  mem_cmd_data_o, mem_cmd_data_v_o,
      output mem_cmd_data_ready_i
   );
endinterface

// File: rtl/bp_me_burst_rr_arb.sv
// rtl/bp_me_burst_rr_arb.sv - round-robin grant (fixed priority under BP_ME_BURST_ARB_FIXED_PRIO_EN)
module bp_me_burst_rr_arb #(
   parameter  int num_req_p   = 2,
   localparam int id_width_lp = $clog2(num_req_p)
) (
   input  logic [num_req_p-1:0]   v_i,
   input  logic [id_width_lp-1:0] rr_ptr_i,
   output logic [num_req_p-1:0]   grant_oh_o,
   output logic [id_width_lp-1:0] grant_id_o,
   output logic                   grant_v_o
);
   logic [2*num_req_p-1:0] dbl;
   logic [num_req_p-1:0]   rot;
   int                     base;
   int                     sum;

`ifdef BP_ME_BURST_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^rr_ptr_i;
   assign dbl  = {v_i, v_i};
   assign rot  = v_i;
   assign base = 0;
`else
   // Rotate so bit 0 of rot is the requester rr_ptr points at; wrap comes from the doubled copy.
   assign dbl  = {v_i, v_i} >> rr_ptr_i;
   assign rot  = dbl[num_req_p-1:0];
   assign base = int'(rr_ptr_i);
`endif

   always_comb begin
      grant_id_o = '0;
      grant_v_o  = 1'b0;
      sum        = 0;
      for (int j = 0; j < num_req_p; j++) begin
         if (!grant_v_o && rot[j]) begin
            grant_v_o = 1'b1;
            sum       = base + j;
            if (sum >= num_req_p) sum = sum - num_req_p;
            grant_id_o = id_width_lp'(sum);
         end
      end
   end

   always_comb begin
      grant_oh_o = '0;
      for (int k = 0; k < num_req_p; k++)
         grant_oh_o[k] = grant_v_o && (grant_id_o == id_width_lp'(k));
   end
endmodule

// File: rtl/bp_me_burst_mem_cmd_arb.sv
// rtl/bp_me_burst_mem_cmd_arb.sv - per-message locked mem_cmd arbiter; BP_ME_BURST_ARB_FIXED_PRIO_EN selects fixed priority
module bp_me_burst_mem_cmd_arb
   import bp_me_pkg::*;
#(
   parameter  int num_req_p      = 2,
   parameter  int header_width_p = 128,
   parameter  int data_width_p   = 64,
   parameter  int max_beats_p    = 8,
   localparam int lg_beats_lp    = $clog2(max_beats_p + 1),
   localparam int id_width_lp    = $clog2(num_req_p)
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   bp_me_burst_mem_cmd_arb_if.slave     cmd_io,
   output logic [id_width_lp-1:0]       grant_id_o
);
   bp_me_burst_arb_state_e   state_q, state_d;
   logic [id_width_lp-1:0]   rr_ptr_q, rr_ptr_d, lock_id_q, lock_id_d;
   logic [lg_beats_lp-1:0]   beat_cnt_q, beat_cnt_d, hdr_beats;
   logic [id_width_lp-1:0]   grant_id, ptr_after_hdr, ptr_after_data;
   logic [num_req_p-1:0]     grant_oh, hdr_rdy, data_rdy;
   logic                     grant_v, hdr_v, data_v, hdr_fire, data_v_mux;
   logic [header_width_p-1:0] hdr_mux;
   logic [data_width_p-1:0]  data_mux;

   bp_me_burst_rr_arb #(.num_req_p(num_req_p)) u_arb (
      .v_i        (cmd_io.req_header_v_i),
      .rr_ptr_i   (rr_ptr_q),
      .grant_oh_o (grant_oh),
      .grant_id_o (grant_id),
      .grant_v_o  (grant_v)
   );

`ifdef BP_ME_BURST_ARB_FIXED_PRIO_EN
   assign ptr_after_hdr  = '0;
   assign ptr_after_data = '0;
`else
   assign ptr_after_hdr  = id_width_lp'(next_idx(int'(grant_id), num_req_p));
   assign ptr_after_data = id_width_lp'(next_idx(int'(lock_id_q), num_req_p));
`endif

   always_comb begin
      hdr_mux    = '0;
      hdr_beats  = '0;
      data_mux   = '0;
      data_v_mux = 1'b0;
      for (int i = 0; i < num_req_p; i++) begin
         if (grant_id == id_width_lp'(i)) begin
            hdr_mux   = cmd_io.req_header_i[i*header_width_p +: header_width_p];
            hdr_beats = cmd_io.req_header_beats_i[i*lg_beats_lp +: lg_beats_lp];
         end
         if (lock_id_q == id_width_lp'(i)) begin
            data_mux   = cmd_io.req_data_i[i*data_width_p +: data_width_p];
            data_v_mux = cmd_io.req_data_v_i[i];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      lock_id_d  = lock_id_q;
      beat_cnt_d = beat_cnt_q;
      hdr_v      = 1'b0;
      data_v     = 1'b0;
      hdr_rdy    = '0;
      data_rdy   = '0;
      hdr_fire   = 1'b0;
      case (state_q)
         e_idle: begin
            hdr_v    = grant_v;
            hdr_rdy  = grant_oh & {num_req_p{cmd_io.mem_cmd_header_ready_i}};
            hdr_fire = grant_v & cmd_io.mem_cmd_header_ready_i;
            if (hdr_fire) begin
               if (hdr_beats == '0) begin
                  rr_ptr_d = ptr_after_hdr;
               end else begin
                  lock_id_d  = grant_id;
                  beat_cnt_d = hdr_beats;
                  state_d    = e_data;
               end
            end
         end
         e_data: begin
            data_v = data_v_mux;
            for (int i = 0; i < num_req_p; i++)
               data_rdy[i] = (lock_id_q == id_width_lp'(i)) & cmd_io.mem_cmd_data_ready_i;
            if (data_v_mux && cmd_io.mem_cmd_data_ready_i) begin
               beat_cnt_d = beat_cnt_q - lg_beats_lp'(1);
               if (beat_cnt_q == lg_beats_lp'(1)) begin
                  state_d  = e_idle;
                  rr_ptr_d = ptr_after_data;
               end
            end
         end
         default: state_d = e_idle;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= e_idle;
         rr_ptr_q   <= '0;
         lock_id_q  <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_id_q  <= lock_id_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Handshake outputs are combinational from requester inputs, so reset must mask them directly.
   assign cmd_io.mem_cmd_header_o   = hdr_mux;
   assign cmd_io.mem_cmd_header_v_o = hdr_v & reset_n_i;
   assign cmd_io.req_header_ready_o = hdr_rdy & {num_req_p{reset_n_i}};
   assign cmd_io.mem_cmd_data_o     = data_mux;
   assign cmd_io.mem_cmd_data_v_o   = data_v & reset_n_i;
   assign cmd_io.req_data_ready_o   = data_rdy & {num_req_p{reset_n_i}};
   assign grant_id_o = (state_q == e_data) ? lock_id_q : grant_id;

   hdr_beats_legal_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      hdr_fire |-> (hdr_beats <= lg_beats_lp'(max_beats_p)));
endmodule

// File: tb/tb_bp_me_burst_mem_cmd_arb.sv
// tb/tb_bp_me_burst_mem_cmd_arb.sv - scoreboard bench for bp_me_burst_mem_cmd_arb
module tb_bp_me_burst_mem_cmd_arb;
   import bp_me_pkg::*;

   localparam int NR = 2;
   localparam int HW = 128;
   localparam int DW = 64;
   localparam int MB = 8;
   localparam int LG = $clog2(MB + 1);

   typedef struct {
      logic [HW-1:0] hdr;
      int            beats;
      int            id;
   } msg_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [0:0] grant_id;
   always #5 clk = ~clk;

   bp_me_burst_mem_cmd_arb_if #(.num_req_p(NR), .header_width_p(HW), .data_width_p(DW), .max_beats_p(MB)) bus ();

   bp_me_burst_mem_cmd_arb #(.num_req_p(NR), .header_width_p(HW), .data_width_p(DW), .max_beats_p(MB)) dut (
      .clk_i      (clk),
      .reset_n_i  (rst_n),
      .cmd_io     (bus),
      .grant_id_o (grant_id)
   );

   int   n_run = 0;
   int   n_fail = 0;
   msg_t req_q [NR][$];
   msg_t exp_q [$];
   msg_t cur_msg [NR];
   bit   active [NR];
   bit   hphase [NR];
   int   bidx [NR];
   msg_t cur;
   bit   cur_valid = 1'b0;
   int   cur_rx = 0;
   bit   toggle_en = 1'b0;
   bit   abort = 1'b0;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] beat_val(input logic [HW-1:0] h, input int j);
      return {h[DW-1:8], 8'(j)};
   endfunction

   function automatic msg_t mk(input int r, input int beats);
      msg_t m;
      m.hdr   = {$urandom, $urandom, $urandom, $urandom};
      m.beats = beats;
      m.id    = r;
      return m;
   endfunction

   function automatic bit all_idle();
      bit idle = (exp_q.size() == 0);
      for (int r = 0; r < NR; r++)
         if (active[r] || req_q[r].size() != 0) idle = 1'b0;
      return idle;
   endfunction

   // Requester models, CCE-MEM sink and output monitor share one process.
   initial begin
      logic [NR-1:0] hf, df;
      bus.req_header_i = '0; bus.req_header_beats_i = '0; bus.req_header_v_i = '0;
      bus.req_data_i = '0; bus.req_data_v_i = '0;
      bus.mem_cmd_header_ready_i = 1'b1; bus.mem_cmd_data_ready_i = 1'b1;
      for (int r = 0; r < NR; r++) begin active[r] = 0; hphase[r] = 0; bidx[r] = 0; end
      forever begin
         @(negedge clk);
         hf = '0; df = '0;
         if (abort) begin
            for (int r = 0; r < NR; r++) begin active[r] = 0; req_q[r].delete(); end
            exp_q.delete(); cur_valid = 0; cur_rx = 0;
         end else if (rst_n) begin
            hf = bus.req_header_v_i & bus.req_header_ready_o;
            df = bus.req_data_v_i & bus.req_data_ready_o;
            if (bus.mem_cmd_header_v_o && bus.mem_cmd_header_ready_i) begin
               if (exp_q.size() == 0) check_eq("hdr_unexpected", 1, 0);
               else begin
                  cur = exp_q.pop_front(); cur_valid = 1; cur_rx = 0;
                  check_eq("hdr", bus.mem_cmd_header_o, cur.hdr);
                  check_eq("hdr_grant_id", grant_id, cur.id);
                  check_eq("hdr_ready", bus.req_header_ready_o, 128'(1) << cur.id);
               end
            end
            if (bus.mem_cmd_data_v_o && bus.mem_cmd_data_ready_i) begin
               if (!cur_valid || cur_rx >= cur.beats) check_eq("data_unexpected", 1, 0);
               else begin
                  check_eq("data", bus.mem_cmd_data_o, beat_val(cur.hdr, cur_rx));
                  check_eq("data_grant_id", grant_id, cur.id);
                  check_eq("beat_cnt", dut.beat_cnt_q, cur.beats - cur_rx);
                  cur_rx++;
               end
            end
            for (int r = 0; r < NR; r++)
               if (bus.req_data_v_i[r] && active[r] && hphase[r])
                  check_eq("data_held_off", bus.req_data_ready_o[r], 0);
         end
         @(posedge clk); #1;
         for (int r = 0; r < NR; r++) begin
            if (rst_n && active[r]) begin
               if (hphase[r] && hf[r]) begin
                  hphase[r] = 0;
                  if (cur_msg[r].beats == 0) active[r] = 0;
               end else if (df[r]) begin
                  bidx[r]++;
                  if (bidx[r] == cur_msg[r].beats) active[r] = 0;
               end
            end
            if (!active[r] && req_q[r].size() != 0) begin
               cur_msg[r] = req_q[r].pop_front();
               active[r] = 1; hphase[r] = 1; bidx[r] = 0;
            end
            bus.req_header_i[r*HW +: HW]       = cur_msg[r].hdr;
            bus.req_header_beats_i[r*LG +: LG] = LG'(cur_msg[r].beats);
            bus.req_header_v_i[r]              = active[r] && hphase[r];
            bus.req_data_v_i[r]                = active[r] && (bidx[r] < cur_msg[r].beats);
            bus.req_data_i[r*DW +: DW]         = beat_val(cur_msg[r].hdr, bidx[r]);
         end
         bus.mem_cmd_data_ready_i = toggle_en ? ~bus.mem_cmd_data_ready_i : 1'b1;
      end
   end

   task automatic wait_done(input string tag);
      bit done = 0;
      for (int c = 0; c < 2000 && !done; c++) begin
         @(negedge clk); #1;
         done = all_idle();
      end
      check_eq({tag, "_done"}, done, 1);
      check_eq({tag, "_state_idle"}, dut.state_q, e_idle);
   endtask

   initial begin
      msg_t m0, m1;
      msg_t a0 [4];
      msg_t a1 [4];
      bit hit;

      // Reset state with a request already waiting: outputs masked, registers at reset values.
      m0 = mk(0, 0);
      req_q[0].push_back(m0); exp_q.push_back(m0);
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_hdr_v", bus.mem_cmd_header_v_o, 0);
      check_eq("rst_hdr_ready", bus.req_header_ready_o, 0);
      check_eq("rst_data_v", bus.mem_cmd_data_v_o, 0);
      check_eq("rst_data_ready", bus.req_data_ready_o, 0);
      check_eq("rst_state", dut.state_q, e_idle);
      check_eq("rst_rr_ptr", dut.rr_ptr_q, 0);
      check_eq("rst_beat_cnt", dut.beat_cnt_q, 0);
      #1 rst_n = 1'b1;
      wait_done("t1_hdr_only");
`ifdef BP_ME_BURST_ARB_FIXED_PRIO_EN
      check_eq("t1_rr_ptr", dut.rr_ptr_q, 0);
`else
      check_eq("t1_rr_ptr", dut.rr_ptr_q, 1);
`endif

      // Pointer back to 0, then two competing 2-beat messages.
      m1 = mk(1, 0);
      req_q[1].push_back(m1); exp_q.push_back(m1);
      wait_done("t2_pre");
      m0 = mk(0, 2); m1 = mk(1, 2);
      req_q[0].push_back(m0); req_q[1].push_back(m1);
      exp_q.push_back(m0); exp_q.push_back(m1);
      wait_done("t2_two_bursts");

      // Full 8-beat burst with the sink throttling every other cycle.
      toggle_en = 1'b1;
      m0 = mk(0, 8);
      req_q[0].push_back(m0); exp_q.push_back(m0);
      wait_done("t3_max_burst");
      check_eq("t3_beat_cnt_end", dut.beat_cnt_q, 0);
      toggle_en = 1'b0;

      // req1 shows data early and must be held off through req0's burst.
      m1 = mk(1, 0);
      req_q[1].push_back(m1); exp_q.push_back(m1);
      wait_done("t4_pre");
      m0 = mk(0, 3); m1 = mk(1, 2);
      req_q[0].push_back(m0); req_q[1].push_back(m1);
      exp_q.push_back(m0); exp_q.push_back(m1);
      wait_done("t4_early_data");

      // Asynchronous reset in the middle of a 4-beat burst.
      m0 = mk(0, 4);
      req_q[0].push_back(m0); exp_q.push_back(m0);
      hit = 0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(negedge clk); #1;
         hit = cur_valid && (cur_rx == 2);
      end
      check_eq("t5_reached_mid_burst", hit, 1);
      check_eq("t5_data_v_before", bus.mem_cmd_data_v_o, 1);
      #1 rst_n = 1'b0; abort = 1'b1;
      #1;
      check_eq("t5_hdr_v", bus.mem_cmd_header_v_o, 0);
      check_eq("t5_data_v", bus.mem_cmd_data_v_o, 0);
      check_eq("t5_hdr_ready", bus.req_header_ready_o, 0);
      check_eq("t5_data_ready", bus.req_data_ready_o, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1; abort = 1'b0;
      #1;
      check_eq("t5_state", dut.state_q, e_idle);
      check_eq("t5_rr_ptr", dut.rr_ptr_q, 0);
      check_eq("t5_beat_cnt", dut.beat_cnt_q, 0);

      // Both requesters continuously valid with header-only messages.
      for (int k = 0; k < 4; k++) begin
         a0[k] = mk(0, 0); a1[k] = mk(1, 0);
         req_q[0].push_back(a0[k]); req_q[1].push_back(a1[k]);
      end
`ifdef BP_ME_BURST_ARB_FIXED_PRIO_EN
      for (int k = 0; k < 4; k++) exp_q.push_back(a0[k]);
      for (int k = 0; k < 4; k++) exp_q.push_back(a1[k]);
`else
      for (int k = 0; k < 4; k++) begin exp_q.push_back(a0[k]); exp_q.push_back(a1[k]); end
`endif
      wait_done("t6_contention");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
